// File: rtl/reg_bank_sb.sv
// reg_bank_sb: ID-stage register file with two registered read ports, one
// writeback port, optional write-to-read bypass, optional hardwired zero
// register and a per-register scoreboard of pending writes.
module reg_bank_sb #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 5,
    parameter int                ZERO_REG  = 1,
    parameter int                BYPASS    = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NREGS = 2**ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [NREGS-1:0]             busy;
    logic [NREGS-1:0]             busy_next;
    logic [ADDR_W:0]              cnt_next;
    logic                         wr_ok;
    logic                         iss_ok;
    logic                         hit1;
    logic                         hit2;
    logic [DATA_W-1:0]            data1_next;
    logic [DATA_W-1:0]            data2_next;
    logic                         busy1_next;
    logic                         busy2_next;

    // Writes and issues aimed at a hardwired zero register are dropped here,
    // so register 0 never changes and never becomes busy.
    assign wr_ok  = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
    assign iss_ok = iss_en && !(ZERO_REG != 0 && iss_addr == '0);

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam logic [DATA_W-1:0] INIT =
                (ZERO_REG != 0 && gi == 0) ? '0 : RESET_VAL;
            logic [DATA_W-1:0] data_reg;
            logic              busy_reg;

            // Storage word: loaded from writeback when addressed.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    data_reg <= INIT;
                else if (wr_ok && wr_addr == ADDR_W'(gi))
                    data_reg <= wr_data;
            end

            // Scoreboard bit: follows the combined write/issue update.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    busy_reg <= 1'b0;
                else
                    busy_reg <= busy_next[gi];
            end

            assign regs[gi] = data_reg;
            assign busy[gi] = busy_reg;
        end
    endgenerate

    // Scoreboard update: write clears first, then issue sets, so a same-cycle
    // issue to the written register (the newer producer) leaves it busy.
    always_comb begin
        busy_next = busy;
        if (wr_ok)
            busy_next[wr_addr] = 1'b0;
        if (iss_ok)
            busy_next[iss_addr] = 1'b1;
    end

    // Population count of the post-update busy vector; one extra bit so a
    // fully busy file does not wrap to zero.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
    end

    // Read-port source selection, forwarding the in-flight write when enabled.
    always_comb begin
        hit1       = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr1);
        hit2       = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr2);
        data1_next = hit1 ? wr_data : regs[rd_addr1];
        data2_next = hit2 ? wr_data : regs[rd_addr2];
        busy1_next = hit1 ? busy_next[rd_addr1] : busy[rd_addr1];
        busy2_next = hit2 ? busy_next[rd_addr2] : busy[rd_addr2];
    end

    // Registered read outputs and busy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_busy1 <= 1'b0;
            rd_busy2 <= 1'b0;
            busy_cnt <= '0;
        end else begin
            rd_data1 <= data1_next;
            rd_data2 <= data2_next;
            rd_busy1 <= busy1_next;
            rd_busy2 <= busy2_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule
